// File: rtl/synth_pkg.sv
// Shared types and constants for the voice mixer: FSM state encoding, the
// channel level format (9-bit, 256 = unity gain) and the saturating level step.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } mix_state_e;

    localparam int              LEVEL_W     = 9;
    localparam logic [LEVEL_W-1:0] LEVEL_UNITY = 9'd256;

    // Move a level one step toward unity (up) or toward zero, saturating at both ends.
    function automatic logic [LEVEL_W-1:0] level_step(
        input logic [LEVEL_W-1:0] cur,
        input logic               up,
        input logic [LEVEL_W-1:0] step
    );
        logic [LEVEL_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (up) begin
            level_step = (sum > {1'b0, LEVEL_UNITY}) ? LEVEL_UNITY : sum[LEVEL_W-1:0];
        end else begin
            level_step = (cur > step) ? (cur - step) : {LEVEL_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/channel_level_ramp.sv
// One channel's gain level register; steps toward unity or silence once per
// enabled cycle. Only instantiated when MIXER_RAMP_EN is defined.
module channel_level_ramp
    import synth_pkg::*;
#(
    parameter int RAMP_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    input  logic               target_on,
    output logic [LEVEL_W-1:0] level
);

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;

    // Next level: one saturating step toward the target when stepping.
    always_comb begin
        level_d = level_q;
        if (step_en) begin
            level_d = level_step(level_q, target_on, LEVEL_W'(RAMP_STEP));
        end else begin
            level_d = level_q;
        end
    end

    // Level register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= {LEVEL_W{1'b0}};
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/voice_mixer.sv
// Sequential N-channel offset-binary mixer: one channel per cycle, clamped output.
// Optional per-channel gain ramping is enabled by defining MIXER_RAMP_EN.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_W     = 11,
    parameter int OUT_W        = 12,
    parameter int RAMP_STEP    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_CHANNELS*SAMPLE_W-1:0] samples,
    input  logic [NUM_CHANNELS-1:0]          ena,
    output logic [OUT_W-1:0]                 mix_out,
    output logic                             mix_valid,
    output logic                             clip,
    output logic                             busy
);

    localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    // sample * 256 summed over up to 16 channels, plus a guard bit
    localparam int ACC_W   = SAMPLE_W + LEVEL_W + 5;
    localparam int SHIFT   = OUT_W - SAMPLE_W - 1;
    localparam int FRAC_SH = 8;
    localparam int RES_W   = ACC_W + SHIFT + 2;
    localparam logic signed [RES_W-1:0] MID_RES =
        $signed({{(RES_W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}});
    localparam logic signed [RES_W-1:0] MAX_RES =
        $signed({{(RES_W-OUT_W){1'b0}}, {OUT_W{1'b1}}});

    mix_state_e                       state_q,   state_d;
    logic [IDX_W-1:0]                 idx_q,     idx_d;
    logic signed [ACC_W-1:0]          acc_q,     acc_d;
    logic [NUM_CHANNELS*SAMPLE_W-1:0] samples_q, samples_d;
    logic [NUM_CHANNELS-1:0]          ena_q,     ena_d;
    logic [OUT_W-1:0]                 mix_out_q, mix_out_d;
    logic                             mix_valid_q, mix_valid_d;
    logic                             clip_q,    clip_d;
    logic                             busy_q,    busy_d;

    logic [SAMPLE_W-1:0]     cur_sample_s;
    logic [LEVEL_W-1:0]      cur_level_s;
    logic signed [ACC_W-1:0] centred_ext_s;
    logic signed [ACC_W-1:0] level_ext_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [RES_W-1:0] acc_wide_s;
    logic signed [RES_W-1:0] res_s;
    logic [OUT_W-1:0]        res_clamped_s;
    logic                    res_clip_s;

`ifdef MIXER_RAMP_EN
    logic [LEVEL_W-1:0] level_arr_s [NUM_CHANNELS];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ramp
        channel_level_ramp #(
            .RAMP_STEP (RAMP_STEP)
        ) u_ramp (
            .clk       (clk),
            .rst       (rst),
            .step_en   (state_q == ST_DONE),
            .target_on (ena_q[g]),
            .level     (level_arr_s[g])
        );
    end
`endif

    // Select the current channel's snapshot sample and its gain level.
    always_comb begin
        cur_sample_s = {SAMPLE_W{1'b0}};
        cur_level_s  = {LEVEL_W{1'b0}};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cur_sample_s = (idx_q == IDX_W'(i)) ? samples_q[i*SAMPLE_W +: SAMPLE_W] : cur_sample_s;
`ifdef MIXER_RAMP_EN
            cur_level_s  = (idx_q == IDX_W'(i)) ? level_arr_s[i] : cur_level_s;
`else
            cur_level_s  = (idx_q == IDX_W'(i)) ? (ena_q[i] ? LEVEL_UNITY : {LEVEL_W{1'b0}})
                                                : cur_level_s;
`endif
        end
    end

    // Accumulate centred sample * level and form the clamped output word.
    always_comb begin
        // flipping the MSB turns offset binary into two's complement
        centred_ext_s = $signed({{(ACC_W-SAMPLE_W+1){~cur_sample_s[SAMPLE_W-1]}},
                                 cur_sample_s[SAMPLE_W-2:0]});
        level_ext_s   = $signed({{(ACC_W-LEVEL_W){1'b0}}, cur_level_s});
        acc_next_s    = acc_q + centred_ext_s * level_ext_s;
        acc_wide_s    = $signed({{(RES_W-ACC_W){acc_next_s[ACC_W-1]}}, acc_next_s});
        res_s         = ((acc_wide_s >>> FRAC_SH) <<< SHIFT) + MID_RES;
        if (res_s[RES_W-1]) begin
            res_clamped_s = {OUT_W{1'b0}};
            res_clip_s    = 1'b1;
        end else if (res_s > MAX_RES) begin
            res_clamped_s = {OUT_W{1'b1}};
            res_clip_s    = 1'b1;
        end else begin
            res_clamped_s = res_s[OUT_W-1:0];
            res_clip_s    = 1'b0;
        end
    end

    // FSM next-state and registered output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        samples_d   = samples_q;
        ena_d       = ena_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        clip_d      = clip_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ACCUM;
                    idx_d     = {IDX_W{1'b0}};
                    acc_d     = {ACC_W{1'b0}};
                    samples_d = samples;
                    ena_d     = ena;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_next_s;
                // the result is registered on entry to DONE so the pulse lines up with DONE
                if (idx_q == IDX_W'(NUM_CHANNELS - 1)) begin
                    state_d     = ST_DONE;
                    mix_out_d   = res_clamped_s;
                    clip_d      = res_clip_s;
                    mix_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            samples_q   <= {(NUM_CHANNELS*SAMPLE_W){1'b0}};
            ena_q       <= {NUM_CHANNELS{1'b0}};
            mix_out_q   <= {1'b1, {(OUT_W-1){1'b0}}};
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            samples_q   <= samples_d;
            ena_q       <= ena_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            clip_q      <= clip_d;
            busy_q      <= busy_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign clip      = clip_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized self-checking bench for voice_mixer: a 2-channel and a 4-channel
// instance checked against an integer-arithmetic reference model.
module tb_voice_mixer;

    localparam int SW = 11;
    localparam int OW = 12;
    localparam int RS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start2, start4;
    logic [2*SW-1:0]   smp2;
    logic [4*SW-1:0]   smp4;
    logic [1:0]        ena2;
    logic [3:0]        ena4;
    logic [OW-1:0]     mo2, mo4;
    logic              mv2, mv4, cl2, cl4, bz2, bz4;

    int n_checks = 0;
    int n_fail   = 0;
    int lvl [2][4];

    voice_mixer #(.NUM_CHANNELS(2), .SAMPLE_W(SW), .OUT_W(OW), .RAMP_STEP(RS)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .samples(smp2), .ena(ena2),
        .mix_out(mo2), .mix_valid(mv2), .clip(cl2), .busy(bz2));

    voice_mixer #(.NUM_CHANNELS(4), .SAMPLE_W(SW), .OUT_W(OW), .RAMP_STEP(RS)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .samples(smp4), .ena(ena4),
        .mix_out(mo4), .mix_valid(mv4), .clip(cl4), .busy(bz4));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: signed sum of (sample - midpoint) * gain, floor-divide by 256, scale, clamp.
    function automatic int model_mix(input int which, input int smp[4], input logic [3:0] en,
                                     output bit clp);
        int     nc;
        int     level;
        longint acc;
        longint q;
        longint r;
        nc  = (which == 0) ? 2 : 4;
        acc = 0;
        for (int i = 0; i < nc; i++) begin
`ifdef MIXER_RAMP_EN
            level = lvl[which][i];
`else
            level = en[i] ? 256 : 0;
`endif
            acc += longint'(smp[i] - 1024) * level;
        end
        q = acc / 256;
        if (acc < 0 && (acc % 256) != 0) q = q - 1;
        r   = 2048 + q * (1 << (OW - SW - 1));
        clp = 1'b0;
        if (r < 0)    begin r = 0;    clp = 1'b1; end
        if (r > 4095) begin r = 4095; clp = 1'b1; end
        return int'(r);
    endfunction

    task automatic ramp_update(input int which, input logic [3:0] en);
`ifdef MIXER_RAMP_EN
        for (int i = 0; i < 4; i++) begin
            if (en[i]) lvl[which][i] = (lvl[which][i] + RS > 256) ? 256 : lvl[which][i] + RS;
            else       lvl[which][i] = (lvl[which][i] - RS < 0)   ? 0   : lvl[which][i] - RS;
        end
`endif
    endtask

    task automatic clear_levels();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 4; i++) lvl[w][i] = 0;
    endtask

    task automatic drive(input int which, input int smp[4], input logic [3:0] en, input logic st);
        if (which == 0) begin
            for (int i = 0; i < 2; i++) smp2[i*SW +: SW] = SW'(smp[i]);
            ena2   = en[1:0];
            start2 = st;
        end else begin
            for (int i = 0; i < 4; i++) smp4[i*SW +: SW] = SW'(smp[i]);
            ena4   = en;
            start4 = st;
        end
    endtask

    task automatic get_out(input int which, output logic [OW-1:0] mo, output logic mv,
                           output logic cl, output logic bz);
        if (which == 0) begin mo = mo2; mv = mv2; cl = cl2; bz = bz2; end
        else            begin mo = mo4; mv = mv4; cl = cl4; bz = bz4; end
    endtask

    task automatic rand_smp(output int smp[4]);
        for (int i = 0; i < 4; i++) smp[i] = int'($urandom_range(0, 2047));
    endtask

    // One frame: start, scramble inputs (and re-request start) while busy, check result.
    task automatic frame(input int which, input int smp[4], input logic [3:0] en,
                         output int got_mo, output bit got_cl);
        int            nc;
        int            exp_mo;
        bit            exp_cl;
        int            n;
        int            junk[4];
        logic [OW-1:0] mo;
        logic          mv, cl, bz;
        nc     = (which == 0) ? 2 : 4;
        exp_mo = model_mix(which, smp, en, exp_cl);
        drive(which, smp, en, 1'b1);
        @(posedge clk); #1;
        rand_smp(junk);
        drive(which, junk, 4'($urandom), 1'b1);
        get_out(which, mo, mv, cl, bz);
        check_eq("busy_after_start", {31'd0, bz}, 32'd1);
        n = 1;
        while (!mv && n < 40) begin
            @(posedge clk); #1;
            n++;
            get_out(which, mo, mv, cl, bz);
        end
        drive(which, junk, 4'($urandom), 1'b0);
        check_eq("latency", n, nc + 1);
        check_eq("mix_out", {20'd0, mo}, exp_mo);
        check_eq("clip", {31'd0, cl}, {31'd0, exp_cl});
        got_mo = int'(mo);
        got_cl = cl;
        ramp_update(which, en);
        @(posedge clk); #1;
        get_out(which, mo, mv, cl, bz);
        check_eq("valid_one_cycle", {31'd0, mv}, 32'd0);
        check_eq("mix_out_held", {20'd0, mo}, exp_mo);
        @(posedge clk); #1;
        get_out(which, mo, mv, cl, bz);
        check_eq("no_queued_start", {31'd0, bz}, 32'd0);
    endtask

    task automatic do_reset();
        int z[4];
        z = '{0, 0, 0, 0};
        drive(0, z, 4'd0, 1'b0);
        drive(1, z, 4'd0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_levels();
    endtask

    initial begin
        int            smp[4];
        int            got;
        bit            gcl;
        int            pulses;
        int            last_e;
        int            exp_mo;
        bit            exp_cl;
        logic [3:0]    en;
        logic [OW-1:0] mo;
        logic          mv, cl, bz;

        rst = 1'b0;
        smp = '{0, 0, 0, 0};
        drive(0, smp, 4'd0, 1'b0);
        drive(1, smp, 4'd0, 1'b0);
        clear_levels();
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            get_out(w, mo, mv, cl, bz);
            check_eq("reset_mix_out", {20'd0, mo}, 32'd2048);
            check_eq("reset_valid", {31'd0, mv}, 32'd0);
            check_eq("reset_clip", {31'd0, cl}, 32'd0);
            check_eq("reset_busy", {31'd0, bz}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

`ifndef MIXER_RAMP_EN
        frame(0, '{2047, 2047, 0, 0}, 4'b0011, got, gcl);
        check_eq("full_scale_2ch", got, 32'd4094);
        check_eq("full_scale_2ch_clip", {31'd0, gcl}, 32'd0);
        frame(0, '{0, 0, 0, 0}, 4'b0011, got, gcl);
        check_eq("neg_scale_2ch", got, 32'd0);
        check_eq("neg_scale_2ch_clip", {31'd0, gcl}, 32'd0);
        frame(0, '{1536, 0, 0, 0}, 4'b0001, got, gcl);
        check_eq("single_chan", got, 32'd2560);
        frame(1, '{2047, 2047, 2047, 2047}, 4'b1111, got, gcl);
        check_eq("clamp_4ch", got, 32'd4095);
        check_eq("clamp_4ch_clip", {31'd0, gcl}, 32'd1);
`else
        begin
            int up_exp[6];
            int dn_exp[5];
            up_exp = '{2048, 2303, 2559, 2815, 3071, 3071};
            dn_exp = '{3071, 2815, 2559, 2303, 2048};
            do_reset();
            for (int f = 0; f < 6; f++) begin
                frame(0, '{2047, 1024, 0, 0}, 4'b0001, got, gcl);
                check_eq("ramp_up", got, up_exp[f]);
            end
            for (int f = 0; f < 5; f++) begin
                frame(0, '{2047, 1024, 0, 0}, 4'b0000, got, gcl);
                check_eq("ramp_down", got, dn_exp[f]);
            end
        end
`endif

        for (int k = 0; k < 24; k++) begin
            rand_smp(smp);
            frame(k % 2, smp, 4'($urandom), got, gcl);
        end

        // start held high: one frame every NUM_CHANNELS+2 cycles
        rand_smp(smp);
        en = 4'($urandom);
        drive(0, smp, en, 1'b1);
        pulses = 0;
        last_e = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            get_out(0, mo, mv, cl, bz);
            if (mv) begin
                pulses++;
                exp_mo = model_mix(0, smp, en, exp_cl);
                check_eq("held_mix_out", {20'd0, mo}, exp_mo);
                check_eq("held_spacing", e - last_e, (last_e == 0) ? 3 : 4);
                last_e = e;
                ramp_update(0, en);
            end
        end
        drive(0, smp, en, 1'b0);
        check_eq("held_pulses", pulses, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        check_eq("held_idle", {31'd0, bz2}, 32'd0);

        // reset in the middle of a frame abandons it
        rand_smp(smp);
        drive(0, smp, 4'b0011, 1'b1);
        @(posedge clk); #1;
        drive(0, smp, 4'b0011, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_busy", {31'd0, bz2}, 32'd0);
        check_eq("midrst_mix_out", {20'd0, mo2}, 32'd2048);
        check_eq("midrst_valid", {31'd0, mv2}, 32'd0);
        rst = 1'b1;
        clear_levels();
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mv2) pulses++;
        end
        check_eq("midrst_no_pulse", pulses, 32'd0);
        rand_smp(smp);
        frame(0, smp, 4'b0011, got, gcl);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of mixed channels (legal 1..16).
REQ-002 Parameter SAMPLE_W, default 11, per-channel unsigned offset-binary sample width.
REQ-003 Parameter OUT_W, default 12, mixed output width (legal: OUT_W >= SAMPLE_W+1).
REQ-004 Parameter RAMP_STEP, default 4, per-frame level increment/decrement (legal 1..256).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  frame request; sampled only in IDLE.
REQ-008 samples  in  NUM_CHANNELS*SAMPLE_W  packed channel samples, channel i at bits [i*SAMPLE_W +: SAMPLE_W].
REQ-009 ena  in  NUM_CHANNELS  per-channel enable.
REQ-010 mix_out  out  OUT_W  mixed offset-binary sample, held between frames.
REQ-011 mix_valid  out  1  one-cycle pulse when mix_out updates.
REQ-012 clip  out  1  set with mix_valid when the frame result was clamped, else 0; held until next mix_valid.
REQ-013 busy  out  1  high in ACCUM and DONE.

Function
REQ-014 FSM states IDLE, ACCUM, DONE; IDLE->ACCUM on start, ACCUM->DONE after channel NUM_CHANNELS-1, DONE->IDLE unconditionally.
REQ-015 On IDLE->ACCUM, samples and ena are snapshotted; later changes do not affect the frame in progress.
REQ-016 ACCUM processes one channel per cycle, index 0 upward; start while busy is ignored (no queuing).
REQ-017 Latency: start accepted in cycle t -> mix_valid high in cycle t+NUM_CHANNELS+1; exactly one pulse per accepted start.
REQ-018 Per channel: s = sample - 2^(SAMPLE_W-1) (signed); acc += s * level[i]; level range 0..256, 256 = unity.
REQ-019 Result: r = 2^(OUT_W-1) + ((acc >>> 8) <<< (OUT_W-SAMPLE_W-1)); arithmetic shift floors.
REQ-020 r is clamped to [0, 2^OUT_W-1]; clip = 1 iff clamping occurred; accumulator sized so no internal overflow at any legal parameters.
REQ-021 The accumulator clears at IDLE->ACCUM; mix_out, clip, and mix_valid are registered in DONE.

Reset
REQ-022 While rst is low: state IDLE, mix_out = 2^(OUT_W-1), mix_valid 0, clip 0, busy 0, all levels 0, accumulator 0.
REQ-023 rst asserted mid-frame abandons the frame; no mix_valid is produced for it.

Configuration
REQ-024 With MIXER_RAMP_EN defined: in each DONE, level[i] moves toward 256 (if snapshot ena[i]) or 0 (if not) by RAMP_STEP, saturating at 0 and 256; the updated level applies from the next frame.
REQ-025 Without MIXER_RAMP_EN: level[i] = snapshot ena[i] ? 256 : 0 within the current frame, and no level registers exist.

Structure
REQ-026 Shared package synth_pkg holds the mixer state enum, LEVEL_W = 9, and LEVEL_UNITY = 256.
REQ-027 Sub-module channel_level_ramp is instantiated once per channel; it holds one level register and the saturating step logic, and is generated only under MIXER_RAMP_EN.

Verification (NUM_CHANNELS=2, SAMPLE_W=11, OUT_W=12, macro off unless stated)
REQ-028 ena=11, samples 2047/2047, start pulse -> mix_valid 3 cycles later, mix_out 4094, clip 0.
REQ-029 ena=11, samples 0/0 -> mix_out 0, clip 0; ena=01, samples 1536/0 -> mix_out 2560.
REQ-030 NUM_CHANNELS=4, OUT_W=12, all ena, all samples 2047 -> mix_out 4095, clip 1, mix_valid at t+5.
REQ-031 MIXER_RAMP_EN, RAMP_STEP=64, ena 0->1 with sample 2047: frame 1 -> 2048, frame 2 -> 2303, frame 5 onward -> 3071; ena->0 ramps back to 2048 over 4 frames.
REQ-032 start held high continuously -> one frame every NUM_CHANNELS+2 cycles; starts issued while busy produce no extra pulses.
REQ-033 rst low during ACCUM -> next cycle: busy 0, mix_out 2048, no mix_valid; a new start then completes normally.
